// File: rtl/sat_pkg.sv
// Shared encodings for the 3-SAT clause scheduler: value/result codes,
// literal layout and the controller state enum.
package sat_pkg;

    localparam int NUM_VARS_DEF = 16;
    localparam int VAR_W_DEF    = $clog2(NUM_VARS_DEF);

    localparam logic [1:0] VAL_FALSE   = 2'b00;
    localparam logic [1:0] VAL_TRUE    = 2'b01;
    localparam logic [1:0] VAL_UNKNOWN = 2'b10;

    localparam logic [1:0] UNSAT   = 2'b00;
    localparam logic [1:0] SAT     = 2'b01;
    localparam logic [1:0] UNKNOWN = 2'b10;

    typedef struct packed {
        logic                 neg;
        logic [VAR_W_DEF-1:0] var_idx;
    } lit_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_FIN
    } state_t;

endpackage

// File: rtl/clause_batch_scheduler_if.sv
// Bundle of config/start inputs and verdict outputs of the scheduler.
// master: search engine side; slave: scheduler side.
interface clause_batch_scheduler_if #(
    parameter int NUM_VARS    = 16,
    parameter int MAX_CLAUSES = 32
);
    localparam int VAR_W  = $clog2(NUM_VARS);
    localparam int LIT_W  = VAR_W + 1;
    localparam int ADDR_W = $clog2(MAX_CLAUSES);

    logic                  cfg_we;
    logic [ADDR_W-1:0]     cfg_addr;
    logic [3*LIT_W-1:0]    cfg_lits;
    logic [ADDR_W:0]       num_clauses;
    logic                  start;
    logic [2*NUM_VARS-1:0] assign_vals;
    logic                  busy;
    logic                  done;
    logic [1:0]            result;
    logic [ADDR_W-1:0]     first_unsat;
    logic [ADDR_W:0]       clauses_checked;

    modport master (
        output cfg_we, cfg_addr, cfg_lits, num_clauses, start, assign_vals,
        input  busy, done, result, first_unsat, clauses_checked
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_lits, num_clauses, start, assign_vals,
        output busy, done, result, first_unsat, clauses_checked
    );

endinterface

// File: rtl/clause_evaluator.sv
// Combinational verdict over NUM_CLAUSES 3-term clauses.
// terms_i: 2-bit term values, clause c at [6c +: 6]; verdict_o: result code.
module clause_evaluator
    import sat_pkg::*;
#(
    parameter int NUM_CLAUSES = 1
) (
    input  logic [6*NUM_CLAUSES-1:0] terms_i,
    output logic [1:0]               verdict_o
);

    logic any_unsat;
    logic any_unk;
    logic sat_c;
    logic unk_c;

    always_comb begin
        any_unsat = 1'b0;
        any_unk   = 1'b0;
        sat_c     = 1'b0;
        unk_c     = 1'b0;
        for (int c = 0; c < NUM_CLAUSES; c++) begin
            sat_c = 1'b0;
            unk_c = 1'b0;
            for (int k = 0; k < 3; k++) begin
                if (terms_i[c*6+2*k +: 2] == VAL_TRUE) sat_c = 1'b1;
                // code 11 counts as unknown
                if (terms_i[c*6+2*k+1]) unk_c = 1'b1;
            end
            if (!sat_c) begin
                if (unk_c) any_unk = 1'b1;
                else       any_unsat = 1'b1;
            end
        end
        if (any_unsat)    verdict_o = UNSAT;
        else if (any_unk) verdict_o = UNKNOWN;
        else              verdict_o = SAT;
    end

endmodule

// File: rtl/clause_batch_scheduler.sv
// Stores a 3-SAT formula and evaluates it BATCH clauses per cycle.
// Ports: clk, rst_n (async low), bus (slave: cfg/start in, verdict out).
module clause_batch_scheduler
    import sat_pkg::*;
#(
    parameter int NUM_VARS    = 16,
    parameter int MAX_CLAUSES = 32,
    parameter int BATCH       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    clause_batch_scheduler_if.slave  bus
);

    localparam int VAR_W  = $clog2(NUM_VARS);
    localparam int LIT_W  = VAR_W + 1;
    localparam int ADDR_W = $clog2(MAX_CLAUSES);
    localparam int CW     = ADDR_W + 1;
    localparam logic [CW-1:0] MAXC = CW'(MAX_CLAUSES);
    localparam logic [CW-1:0] STEP = CW'(BATCH);
    localparam logic [5:0]    PAD  = {VAL_TRUE, VAL_TRUE, VAL_TRUE};

    state_t                state_q, state_d;
    logic [2*NUM_VARS-1:0] assign_q, assign_d;
    logic [CW-1:0]         n_q, n_d;
    logic [CW-1:0]         base_q, base_d;
    logic [CW-1:0]         cc_q, cc_d;
    logic                  unk_q, unk_d;
    logic [1:0]            res_q, res_d;
    logic [ADDR_W-1:0]     fu_q, fu_d;

    logic [3*LIT_W-1:0]    mem_q [MAX_CLAUSES];
    logic [6*BATCH-1:0]    terms;
    logic [2*BATCH-1:0]    verd;
    logic [CW-1:0]         idx;
    logic                  hit;
    logic                  any_unk;
    logic [ADDR_W-1:0]     lo;
    logic [CW-1:0]         n_in;
    logic [CW-1:0]         last_cc;

    // Negation swaps False/True; unknown and out-of-range stay unknown.
    function automatic logic [1:0] map_lit(
        input logic [LIT_W-1:0]      lit,
        input logic [2*NUM_VARS-1:0] av
    );
        logic [1:0] v;
        if (int'(lit[VAR_W-1:0]) >= NUM_VARS) v = VAL_UNKNOWN;
        else v = av[{lit[VAR_W-1:0], 1'b0} +: 2];
        if (v[1])            v = VAL_UNKNOWN;
        else if (lit[VAR_W]) v = {1'b0, ~v[0]};
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (bus.cfg_we && state_q == S_IDLE) begin
            mem_q[bus.cfg_addr] <= bus.cfg_lits;
        end
    end

    // Slots past the active count are padded to an always-SAT clause.
    always_comb begin
        terms = '0;
        idx   = '0;
        for (int j = 0; j < BATCH; j++) begin
            idx = base_q + CW'(j);
            if (idx < n_q) begin
                for (int k = 0; k < 3; k++) begin
                    terms[j*6+2*k +: 2] = map_lit(
                        mem_q[idx[ADDR_W-1:0]][k*LIT_W +: LIT_W], assign_q);
                end
            end else begin
                terms[j*6 +: 6] = PAD;
            end
        end
    end

    for (genvar g = 0; g < BATCH; g++) begin : g_ce
        clause_evaluator #(
            .NUM_CLAUSES(1)
        ) u_ce (
            .terms_i   (terms[g*6 +: 6]),
            .verdict_o (verd[g*2 +: 2])
        );
    end

    always_comb begin
        hit     = 1'b0;
        lo      = '0;
        any_unk = 1'b0;
        for (int j = 0; j < BATCH; j++) begin
            if (verd[j*2 +: 2] == UNSAT && !hit) begin
                hit = 1'b1;
                lo  = ADDR_W'(j);
            end
            if (verd[j*2 +: 2] == UNKNOWN) any_unk = 1'b1;
        end
    end

    assign n_in    = (bus.num_clauses > MAXC) ? MAXC : bus.num_clauses;
    assign last_cc = (base_q + STEP > n_q) ? n_q : base_q + STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            assign_q <= '0;
            n_q      <= '0;
            base_q   <= '0;
            cc_q     <= '0;
            unk_q    <= 1'b0;
            res_q    <= UNKNOWN;
            fu_q     <= '0;
        end else begin
            state_q  <= state_d;
            assign_q <= assign_d;
            n_q      <= n_d;
            base_q   <= base_d;
            cc_q     <= cc_d;
            unk_q    <= unk_d;
            res_q    <= res_d;
            fu_q     <= fu_d;
        end
    end

    // Finishing is decided one cycle after the last real batch, when
    // base has moved past n.
    always_comb begin
        state_d  = state_q;
        assign_d = assign_q;
        n_d      = n_q;
        base_d   = base_q;
        cc_d     = cc_q;
        unk_d    = unk_q;
        res_d    = res_q;
        fu_d     = fu_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    assign_d = bus.assign_vals;
                    n_d      = n_in;
                    base_d   = '0;
                    unk_d    = 1'b0;
                    cc_d     = '0;
                    if (n_in == '0) begin
                        res_d   = SAT;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                if (base_q >= n_q) begin
                    res_d   = unk_q ? UNKNOWN : SAT;
                    cc_d    = n_q;
                    state_d = S_FIN;
                end else if (hit) begin
                    res_d   = UNSAT;
                    fu_d    = base_q[ADDR_W-1:0] + lo;
                    cc_d    = last_cc;
                    state_d = S_FIN;
                end else begin
                    unk_d  = unk_q | any_unk;
                    base_d = base_q + STEP;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == S_EVAL);
        bus.done = (state_q == S_FIN);
    end

    assign bus.result          = res_q;
    assign bus.first_unsat     = fu_q;
    assign bus.clauses_checked = cc_q;

endmodule

// File: tb/tb_clause_batch_scheduler.sv
// Scoreboard bench for clause_batch_scheduler: directed cases plus
// random formulas checked against a clause-by-clause reference model.
module tb_clause_batch_scheduler;

    typedef struct {
        logic [1:0] res;
        int         fu;
        int         cc;
        int         dc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [14:0] mmem [32];

    localparam logic [31:0] ALL_T = 32'h5555_5555;

    clause_batch_scheduler_if #(.NUM_VARS(16), .MAX_CLAUSES(32)) bus ();

    clause_batch_scheduler #(
        .NUM_VARS(16),
        .MAX_CLAUSES(32),
        .BATCH(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d (cycle %0d)", nm, got, want, cyc);
        end
    endfunction

    function automatic logic [14:0] cl(bit n0, int v0, bit n1, int v1,
                                       bit n2, int v2);
        return {n2, v2[3:0], n1, v1[3:0], n0, v0[3:0]};
    endfunction

    function automatic int lit_val(logic [4:0] l, logic [31:0] av);
        int vi;
        int v;
        vi = int'(l[3:0]);
        v  = int'(av[2*vi +: 2]);
        if (v == 3) v = 2;
        if (l[4] && v != 2) v = (v == 0) ? 1 : 0;
        return v;
    endfunction

    // 1 = satisfied, 2 = undecided, 0 = falsified
    function automatic int clause_val(logic [14:0] c, logic [31:0] av);
        int v[3];
        for (int k = 0; k < 3; k++) v[k] = lit_val(c[k*5 +: 5], av);
        if (v[0] == 1 || v[1] == 1 || v[2] == 1) return 1;
        if (v[0] == 2 || v[1] == 2 || v[2] == 2) return 2;
        return 0;
    endfunction

    function automatic exp_t model(int n_raw, logic [31:0] av, int sc);
        exp_t e;
        int   n;
        bit   unk;
        int   v;
        n    = (n_raw > 32) ? 32 : n_raw;
        unk  = 0;
        e.fu = 0;
        if (n == 0) begin
            e.res = 2'b01; e.cc = 0; e.dc = sc + 1;
            return e;
        end
        for (int i = 0; i < n; i++) begin
            v = clause_val(mmem[i], av);
            if (v == 0) begin
                e.res = 2'b00;
                e.fu  = i;
                e.cc  = ((i / 4 + 1) * 4 > n) ? n : (i / 4 + 1) * 4;
                e.dc  = sc + 2 + i / 4;
                return e;
            end
            if (v == 2) unk = 1;
        end
        e.res = unk ? 2'b10 : 2'b01;
        e.cc  = n;
        e.dc  = sc + 2 + (n + 3) / 4;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got 1 want 0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("result", int'(bus.result), int'(e.res));
                chk("clauses_checked", int'(bus.clauses_checked), e.cc);
                chk("done_cycle", cyc, e.dc);
                chk("busy_in_fin", int'(bus.busy), 0);
                if (e.res == 2'b00)
                    chk("first_unsat", int'(bus.first_unsat), e.fu);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(int a, logic [14:0] l);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a[4:0];
        bus.cfg_lits = l;
        mmem[a]      = l;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic launch(int n, logic [31:0] av);
        bus.num_clauses = n[5:0];
        bus.assign_vals = av;
        bus.start       = 1'b1;
        exp_q.push_back(model(n, av, cyc));
        tick();
        bus.start       = 1'b0;
        bus.assign_vals = $urandom;
        chk("busy_cycle1", int'(bus.busy), (n != 0) ? 1 : 0);
    endtask

    task automatic finish_run();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        chk("run_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run(int n, logic [31:0] av);
        launch(n, av);
        finish_run();
    endtask

    function automatic logic [14:0] orig(int i);
        return cl(0, i % 16, 0, (i + 1) % 16, 0, (i + 2) % 16);
    endfunction

    initial begin
        logic [31:0] av;
        int          n;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_lits    = '0;
        bus.num_clauses = '0;
        bus.start       = 1'b0;
        bus.assign_vals = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_result", int'(bus.result), 2);
        chk("rst_first_unsat", int'(bus.first_unsat), 0);
        chk("rst_cc", int'(bus.clauses_checked), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) wr(i, orig(i));
        run(8, ALL_T);

        wr(5, cl(1, 0, 1, 1, 1, 2));
        run(8, ALL_T);
        wr(5, orig(5));

        wr(2, cl(0, 13, 0, 14, 0, 15));
        av = ALL_T;
        av[26 +: 6] = 6'b101010;
        run(8, av);
        wr(2, orig(2));

        run(0, ALL_T);

        wr(6, cl(1, 0, 1, 1, 1, 2));
        run(6, ALL_T);
        run(8, ALL_T);
        wr(6, orig(6));

        run(40, ALL_T);

        // cfg_we and start while busy must both be dropped
        launch(32, ALL_T);
        tick();
        bus.cfg_we      = 1'b1;
        bus.cfg_addr    = 5'd31;
        bus.cfg_lits    = cl(1, 0, 1, 1, 1, 2);
        bus.start       = 1'b1;
        bus.num_clauses = 6'd8;
        tick();
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
        finish_run();
        run(32, ALL_T);

        // write and start in the same idle cycle
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 5'd1;
        bus.cfg_lits = cl(1, 0, 1, 1, 1, 2);
        mmem[1]      = bus.cfg_lits;
        launch(8, ALL_T);
        bus.cfg_we = 1'b0;
        finish_run();
        wr(1, orig(1));

        // reset in cycle 2 of a full-depth run
        wr(20, cl(1, 4, 1, 5, 1, 6));
        launch(32, ALL_T);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_result", int'(bus.result), 2);
        chk("midrst_first_unsat", int'(bus.first_unsat), 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        run(32, ALL_T);

        for (int r = 0; r < 40; r++) begin
            for (int w = 0; w < int'($urandom_range(0, 6)); w++) begin
                wr($urandom_range(0, 31),
                   cl($urandom_range(0, 1), $urandom_range(0, 15),
                      $urandom_range(0, 1), $urandom_range(0, 15),
                      $urandom_range(0, 1), $urandom_range(0, 15)));
            end
            av = $urandom;
            if (r % 3 == 0) av = av | ALL_T;
            n = $urandom_range(0, 40);
            run(n, av);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
